ahb_master_ctrl: RTL and testbench

AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_burst_len.sv | 35 +++
 rtl/ahb_master_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ahb_master_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB master controller: HTRANS codes, HBURST codes,
// FSM states and the default clamp for undefined-length INCR bursts.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  localparam int MAX_INCR_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA,
    ST_ERR
  } state_t;

endpackage

// File: rtl/ahb_burst_len.sv
// Beat-total decode: turns a latched HBURST code and requested length into
// the number of beats the controller must run.
module ahb_burst_len
  import ahb_pkg::*;
#(
  parameter int MAX_INCR = MAX_INCR_DEFAULT
) (
  input  logic [2:0] burst,
  input  logic [4:0] len,
  output logic [4:0] total
);

  // Fixed-length bursts decode directly; INCR uses len with 0 promoted to 1
  // and anything past MAX_INCR clamped.
  always_comb begin
    total = 5'd1;
    case (burst)
      BURST_SINGLE: total = 5'd1;
      BURST_INCR: begin
        if (len == 5'd0) begin
          total = 5'd1;
        end else if (int'(len) > MAX_INCR) begin
          total = 5'(MAX_INCR);
        end else begin
          total = len;
        end
      end
      BURST_WRAP4, BURST_INCR4:   total = 5'd4;
      BURST_WRAP8, BURST_INCR8:   total = 5'd8;
      BURST_WRAP16, BURST_INCR16: total = 5'd16;
      default:                    total = 5'd1;
    endcase
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// AHB master transfer controller: accepts one request at a time, walks the
// address/data phases of each beat, and drives datapath strobes.
module ahb_master_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MAX_INCR = MAX_INCR_DEFAULT
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr_req,
  input  logic [2:0]        size_req,
  input  logic [2:0]        burst_req,
  input  logic [4:0]        len_req,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic              start_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [2:0]        size_out,
  output logic [2:0]        burst_out,
  output logic              next_beat,
  output logic              store_read,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_reg, state_next;
  logic [4:0]          count_reg, count_next;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [2:0]          size_reg;
  logic [2:0]          burst_reg;
  logic [4:0]          len_reg;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                capture;
  logic [4:0]          total;
  logic                final_beat;
  logic [1:0]          htrans_next;
  logic                start_next;
  logic                next_beat_next;
  logic                store_read_next;

  ahb_burst_len #(
    .MAX_INCR(MAX_INCR)
  ) u_burst_len (
    .burst(burst_reg),
    .len  (len_reg),
    .total(total)
  );

  assign final_beat = (count_reg == total - 5'd1);

  // Next-state, counter and strobe decode; strobes are combinational so the
  // datapath sees them in the same cycle HREADY completes the data phase.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    htrans_next     = HTRANS_IDLE;
    start_next      = 1'b0;
    next_beat_next  = 1'b0;
    store_read_next = 1'b0;
    done_next       = 1'b0;
    err_next        = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          capture    = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        start_next = 1'b1;
        count_next = 5'd0;
        state_next = ST_ADDR;
      end
      ST_ADDR: begin
        htrans_next = (count_reg == 5'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        if (HREADY) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HRESP) begin
          // Error response: drop to IDLE on the bus; a same-cycle HREADY
          // means the two-cycle response was collapsed, so abort at once.
          htrans_next = HTRANS_IDLE;
          if (HREADY) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_ERR;
          end
        end else begin
          htrans_next = final_beat ? HTRANS_IDLE : HTRANS_BUSY;
          if (HREADY) begin
            next_beat_next  = 1'b1;
            store_read_next = ~write_reg;
            count_next      = count_reg + 5'd1;
            if (final_beat) begin
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_ADDR;
            end
          end
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, beat counter, completion pulses and latched request attributes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      count_reg <= 5'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= 3'd0;
      burst_reg <= 3'd0;
      len_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (capture) begin
        write_reg <= write_req;
        addr_reg  <= addr_req;
        size_reg  <= size_req;
        burst_reg <= burst_req;
        len_reg   <= len_req;
      end
    end
  end

  assign HTRANS     = htrans_next;
  assign HWRITE     = write_reg;
  assign start_out  = start_next;
  assign addr_out   = addr_reg;
  assign size_out   = size_reg;
  assign burst_out  = burst_reg;
  assign next_beat  = next_beat_next;
  assign store_read = store_read_next;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Bench for ahb_master_ctrl: a transaction-level driver builds the expected
// per-cycle outputs from the burst rules; a compare process checks them.
module tb_ahb_master_ctrl;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       req = 1'b0, write_req = 1'b0;
  logic [7:0] addr_req = 8'h0;
  logic [2:0] size_req = 3'd0, burst_req = 3'd0;
  logic [4:0] len_req = 5'd0;
  logic       HREADY = 1'b0, HRESP = 1'b0;
  logic [1:0] HTRANS;
  logic       HWRITE, start_out, next_beat, store_read, busy, done, err;
  logic [7:0] addr_out;
  logic [2:0] size_out, burst_out;

  ahb_master_ctrl #(.ADDR_W(8), .MAX_INCR(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .write_req(write_req),
    .addr_req(addr_req), .size_req(size_req), .burst_req(burst_req),
    .len_req(len_req), .HREADY(HREADY), .HRESP(HRESP), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .start_out(start_out), .addr_out(addr_out),
    .size_out(size_out), .burst_out(burst_out), .next_beat(next_beat),
    .store_read(store_read), .busy(busy), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0] htrans;
    logic       hwrite, start, nb, sr, busy, done, err;
    logic [7:0] addr;
    logic [2:0] size, burst;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int checks = 0, errors = 0;
  int cyc = 0;
  int nb_cnt = 0, sr_cnt = 0, err_cnt = 0, done_cyc = -1;
  logic       m_wr = 1'b0;
  logic [7:0] m_addr = 8'h0;
  logic [2:0] m_size = 3'd0, m_burst = 3'd0;

  // Free-running cycle index used to time done relative to the request.
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic int beats(input logic [2:0] b, input logic [4:0] l);
    case (b)
      3'b000: return 1;
      3'b001: return (l == 0) ? 1 : ((l > 16) ? 16 : int'(l));
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ht, input logic st, input logic nb,
                              input logic sr, input logic bz, input logic dn, input logic er);
    exp_t e;
    e.htrans = ht; e.start = st; e.nb = nb; e.sr = sr; e.busy = bz;
    e.done = dn; e.err = er; e.hwrite = m_wr; e.addr = m_addr;
    e.size = m_size; e.burst = m_burst;
    return e;
  endfunction

  // Compare every expected cycle against the DUT away from the clock edge.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("htrans", int'(HTRANS), int'(cur.htrans));
      chk("hwrite", int'(HWRITE), int'(cur.hwrite));
      chk("start_out", int'(start_out), int'(cur.start));
      chk("next_beat", int'(next_beat), int'(cur.nb));
      chk("store_read", int'(store_read), int'(cur.sr));
      chk("busy", int'(busy), int'(cur.busy));
      chk("done", int'(done), int'(cur.done));
      chk("err", int'(err), int'(cur.err));
      chk("addr_out", int'(addr_out), int'(cur.addr));
      chk("size_out", int'(size_out), int'(cur.size));
      chk("burst_out", int'(burst_out), int'(cur.burst));
      if (next_beat) nb_cnt++;
      if (store_read) sr_cnt++;
      if (err) err_cnt++;
      if (done) done_cyc = cyc;
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  // Junk request traffic while busy; none of it may be captured.
  task automatic noise();
    req = 1'($urandom_range(0, 1));
    write_req = 1'($urandom);
    addr_req = 8'($urandom);
    size_req = 3'($urandom);
    burst_req = 3'($urandom);
    len_req = 5'($urandom);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_htrans"}, int'(HTRANS), 0);
    chk({tag, "_hwrite"}, int'(HWRITE), 0);
    chk({tag, "_start"}, int'(start_out), 0);
    chk({tag, "_nb"}, int'(next_beat), 0);
    chk({tag, "_sr"}, int'(store_read), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_addr"}, int'(addr_out), 0);
    chk({tag, "_burst"}, int'(burst_out), 0);
  endtask

  // One transfer: request, START, then per beat an address and data phase.
  task automatic run_txn(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                         input logic [2:0] b, input logic [4:0] l, input bit rnd,
                         input int err_beat, input int err_kind, input int wait_beat,
                         input int wait_n, input int rst_beat, output int req_cyc);
    int total;
    total = beats(b, l);
    req = 1'b1; write_req = wr; addr_req = a; size_req = sz; burst_req = b; len_req = l;
    HREADY = 1'($urandom); HRESP = 1'b0;
    req_cyc = cyc;
    step(mk(T_IDLE, 0, 0, 0, 0, 0, 0));
    m_wr = wr; m_addr = a; m_size = sz; m_burst = b;
    noise(); HREADY = 1'($urandom);
    step(mk(T_IDLE, 1, 0, 0, 1, 0, 0));
    for (int k = 0; k < total; k++) begin
      int wa, wd, we;
      logic [1:0] aht, dht;
      aht = (k == 0) ? T_NSEQ : T_SEQ;
      wa = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int i = 0; i < wa; i++) begin
        noise(); HREADY = 1'b0; HRESP = 1'b0;
        step(mk(aht, 0, 0, 0, 1, 0, 0));
      end
      noise(); HREADY = 1'b1; HRESP = 1'b0;
      step(mk(aht, 0, 0, 0, 1, 0, 0));
      if (k == rst_beat) begin
        req = 1'b0;
        HRESETn = 1'b0;
        #1;
        rst_chk("rst_mid");
        m_wr = 1'b0; m_addr = 8'h0; m_size = 3'd0; m_burst = 3'd0;
        @(posedge HCLK); #1;
        rst_chk("rst_hold");
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        return;
      end
      dht = (k == total - 1) ? T_IDLE : T_BUSY;
      wd = rnd ? int'($urandom_range(0, 2)) : ((k == wait_beat) ? wait_n : 0);
      for (int i = 0; i < wd; i++) begin
        noise(); HREADY = 1'b0; HRESP = 1'b0;
        step(mk(dht, 0, 0, 0, 1, 0, 0));
      end
      if (k == err_beat) begin
        noise(); HRESP = 1'b1;
        if (err_kind == 0) begin
          HREADY = 1'b0;
          step(mk(T_IDLE, 0, 0, 0, 1, 0, 0));
          we = rnd ? int'($urandom_range(0, 2)) : 0;
          for (int i = 0; i < we; i++) begin
            noise(); HREADY = 1'b0; HRESP = 1'($urandom);
            step(mk(T_IDLE, 0, 0, 0, 1, 0, 0));
          end
          noise(); HREADY = 1'b1; HRESP = rnd ? 1'($urandom) : 1'b1;
          step(mk(T_IDLE, 0, 0, 0, 1, 0, 0));
        end else begin
          HREADY = 1'b1;
          step(mk(T_IDLE, 0, 0, 0, 1, 0, 0));
        end
        req = 1'b0; HREADY = 1'($urandom); HRESP = 1'b0;
        step(mk(T_IDLE, 0, 0, 0, 0, 0, 1));
        return;
      end
      noise(); HREADY = 1'b1; HRESP = 1'b0;
      step(mk(dht, 0, 1, ~wr, 1, 0, 0));
    end
    req = 1'b0; HREADY = 1'($urandom); HRESP = 1'b0;
    step(mk(T_IDLE, 0, 0, 0, 0, 1, 0));
  endtask

  initial begin
    int rc, nb0, sr0, er0, tot, eb;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    rst_chk("reset");
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Read SINGLE zero-wait: done four cycles after the request.
    nb0 = nb_cnt; sr0 = sr_cnt; done_cyc = -1;
    run_txn(1'b0, 8'h10, 3'd0, 3'b000, 5'd0, 0, -1, 0, -1, 0, -1, rc);
    chk("single_done_cycle", done_cyc - rc, 4);
    chk("single_next_beats", nb_cnt - nb0, 1);
    chk("single_store_reads", sr_cnt - sr0, 1);

    // Write INCR4 zero-wait: done at cycle 10, no read captures.
    nb0 = nb_cnt; sr0 = sr_cnt; done_cyc = -1;
    run_txn(1'b1, 8'h20, 3'd2, 3'b011, 5'd0, 0, -1, 0, -1, 0, -1, rc);
    chk("incr4_done_cycle", done_cyc - rc, 10);
    chk("incr4_next_beats", nb_cnt - nb0, 4);
    chk("incr4_store_reads", sr_cnt - sr0, 0);

    // Read WRAP8 with two wait states in one data phase.
    sr0 = sr_cnt; done_cyc = -1;
    run_txn(1'b0, 8'h40, 3'd2, 3'b100, 5'd0, 0, -1, 0, 3, 2, -1, rc);
    chk("wrap8_done_cycle", done_cyc - rc, 20);
    chk("wrap8_store_reads", sr_cnt - sr0, 8);

    // Undefined-length INCR at the length boundaries.
    nb0 = nb_cnt;
    run_txn(1'b1, 8'h50, 3'd0, 3'b001, 5'd0, 0, -1, 0, -1, 0, -1, rc);
    chk("incr_len0_beats", nb_cnt - nb0, 1);
    nb0 = nb_cnt;
    run_txn(1'b1, 8'h54, 3'd0, 3'b001, 5'd31, 0, -1, 0, -1, 0, -1, rc);
    chk("incr_len31_beats", nb_cnt - nb0, 16);

    // Two-cycle error response in beat 2 of INCR8.
    nb0 = nb_cnt; er0 = err_cnt; done_cyc = -1;
    run_txn(1'b0, 8'h60, 3'd1, 3'b101, 5'd0, 0, 2, 0, -1, 0, -1, rc);
    chk("err_pulses", err_cnt - er0, 1);
    chk("err_next_beats", nb_cnt - nb0, 2);
    chk("err_no_done", done_cyc, -1);

    // Reset in beat 2 of INCR16, then a clean transfer.
    nb0 = nb_cnt; er0 = err_cnt; done_cyc = -1;
    run_txn(1'b1, 8'h70, 3'd2, 3'b111, 5'd0, 0, -1, 0, -1, 0, 2, rc);
    req = 1'b0;
    step(mk(T_IDLE, 0, 0, 0, 0, 0, 0));
    chk("rst_no_err", err_cnt - er0, 0);
    chk("rst_no_done", done_cyc, -1);
    chk("rst_next_beats", nb_cnt - nb0, 2);
    run_txn(1'b1, 8'h74, 3'd0, 3'b000, 5'd0, 0, -1, 0, -1, 0, -1, rc);

    // Randomized transfers with waits, errors and ignored requests.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] rb;
      logic [4:0] rl;
      rb = 3'($urandom);
      rl = 5'($urandom);
      tot = beats(rb, rl);
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
      run_txn(1'($urandom), 8'($urandom), 3'($urandom), rb, rl, 1, eb,
              int'($urandom_range(0, 1)), -1, 0, -1, rc);
      if ($urandom_range(0, 2) == 0) begin
        req = 1'b0; HREADY = 1'($urandom);
        step(mk(T_IDLE, 0, 0, 0, 0, 0, 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
